// File: rtl/multi_channel_delay_line.sv
//==============================================================================
// Module   : multi_channel_delay_line
// Summary  : CHANNELS x WIDTH lanes delayed 1..DEPTH clocks through a circular
//            buffer; cfg_load reprograms the delay and flushes in-flight data.
// Options  : define DELAY_LINE_STATS_EN to add sample_count / drop_count ports.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module multi_channel_delay_line #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 16,
    parameter int CFG_W    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      cfg_load,
    input  logic [CFG_W-1:0]          cfg_delay,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      busy,
    output logic [CFG_W-1:0]          cur_delay
`ifdef DELAY_LINE_STATS_EN
    ,
    output logic [15:0]               sample_count,
    output logic [15:0]               drop_count
`endif
);

    localparam int c_data_w = CHANNELS * WIDTH;
    localparam int c_cnt_w  = CFG_W + 1;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_flush_cnt;
    logic [c_cnt_w-1:0]  w_flush_cnt_next;
    logic [CFG_W-1:0]    r_wr_ptr;
    logic [CFG_W-1:0]    r_cur_delay;
    logic [CFG_W-1:0]    w_rd_idx;
    logic [DEPTH-1:0]    r_mem_valid;
    logic [DEPTH-1:0]    w_mem_valid_next;
    logic [c_data_w-1:0] r_mem_data [DEPTH];
    logic                r_out_valid;
    logic [c_data_w-1:0] r_out_data;
    logic                w_rd_valid;
    logic [c_data_w-1:0] w_rd_data;

    // Read happens before the same-cycle write; delay 0 bypasses the buffer.
    assign w_rd_idx   = r_wr_ptr - r_cur_delay;
    assign w_rd_valid = (r_cur_delay == '0) ? in_valid : r_mem_valid[w_rd_idx];
    assign w_rd_data  = (r_cur_delay == '0) ? in_data  : r_mem_data[w_rd_idx];

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        if (cfg_load) begin
            w_state_next     = ST_FLUSH;
            w_flush_cnt_next = c_cnt_w'(cfg_delay) + c_cnt_w'(1);
        end else if (en && (r_state == ST_FLUSH)) begin
            w_flush_cnt_next = r_flush_cnt - c_cnt_w'(1);
            if (r_flush_cnt == c_cnt_w'(1)) begin
                w_state_next = ST_RUN;
            end
        end
    end

    // Clear from a load applies before the same-cycle write.
    always_comb begin
        w_mem_valid_next = cfg_load ? '0 : r_mem_valid;
        if (en) begin
            w_mem_valid_next[r_wr_ptr] = in_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
            r_wr_ptr    <= '0;
            r_cur_delay <= '0;
            r_mem_valid <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
            r_mem_valid <= w_mem_valid_next;
            if (cfg_load) begin
                r_cur_delay <= cfg_delay;
            end
            if (en) begin
                r_wr_ptr    <= r_wr_ptr + CFG_W'(1);
                r_out_valid <= w_rd_valid;
                r_out_data  <= w_rd_data;
            end
            if (cfg_load) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            r_mem_data[r_wr_ptr] <= in_data;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = (r_state == ST_FLUSH);
    assign cur_delay = r_cur_delay;

`ifdef DELAY_LINE_STATS_EN
    logic [c_cnt_w-1:0] w_valid_pop;
    logic [16:0]        w_drop_sum;
    logic [15:0]        r_sample_count;
    logic [15:0]        r_drop_count;

    always_comb begin
        w_valid_pop = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_pop = w_valid_pop + c_cnt_w'(r_mem_valid[i]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_count} + 17'(w_valid_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_count <= '0;
            r_drop_count   <= '0;
        end else if (cfg_load) begin
            r_sample_count <= '0;
            r_drop_count   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end else if (en && w_rd_valid && (r_sample_count != 16'hFFFF)) begin
            r_sample_count <= r_sample_count + 16'd1;
        end
    end

    assign sample_count = r_sample_count;
    assign drop_count   = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_delay_line.sv
//==============================================================================
// Module   : tb_multi_channel_delay_line
// Summary  : Directed scenarios plus randomized traffic against a history-based
//            reference model of multi_channel_delay_line (WIDTH=8, CHANNELS=2).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multi_channel_delay_line;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        cfg_load;
    logic [3:0]  cfg_delay;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        busy;
    logic [3:0]  cur_delay;
`ifdef DELAY_LINE_STATS_EN
    logic [15:0] sample_count;
    logic [15:0] drop_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: every enabled cycle's input, indexed by enabled-cycle number.
    bit          h_valid [$];
    logic [15:0] h_data  [$];
    int          m_load_n, m_delay, m_busy_left, m_samples, m_drops;
    bit          m_ov;
    logic [15:0] m_od;

    multi_channel_delay_line #(
        .WIDTH    (8),
        .CHANNELS (2),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .cfg_load     (cfg_load),
        .cfg_delay    (cfg_delay),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .busy         (busy),
`ifdef DELAY_LINE_STATS_EN
        .sample_count (sample_count),
        .drop_count   (drop_count),
`endif
        .cur_delay    (cur_delay)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_load_n    = h_valid.size();
        m_delay     = 0;
        m_busy_left = 0;
        m_ov        = 1'b0;
        m_od        = '0;
        m_samples   = 0;
        m_drops     = 0;
    endtask

    task automatic model_step();
        int pre, idx, lo, cnt;
        pre = h_valid.size();
        if (en) begin
            h_valid.push_back(in_valid);
            h_data.push_back(in_data);
        end
        if (cfg_load) begin
            cnt = 0;
            lo  = (pre - DEPTH > m_load_n) ? pre - DEPTH : m_load_n;
            for (int i = lo; i < pre; i++) if (h_valid[i]) cnt++;
            m_drops     = (m_drops + cnt > 65535) ? 65535 : m_drops + cnt;
            m_delay     = int'(cfg_delay);
            m_ov        = 1'b0;
            m_busy_left = m_delay + 1;
            m_load_n    = pre;
            m_samples   = 0;
        end else if (en) begin
            idx = pre - m_delay;
            if (idx >= m_load_n) begin
                m_ov = h_valid[idx];
                m_od = h_data[idx];
            end else begin
                m_ov = 1'b0;
            end
            if (m_ov && m_samples < 65535) m_samples++;
            if (m_busy_left > 0) m_busy_left--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic test_reset();
        en = 1'b1; cfg_load = 1'b1; cfg_delay = 4'd5; in_valid = 1'b1; in_data = 16'h3C3C;
        tick();
        cfg_load = 1'b0;
        repeat (3) begin
            in_data = 16'($urandom);
            tick();
        end
        @(negedge clk);
        #2;
        en = 1'($urandom); cfg_load = 1'b0; cfg_delay = 4'($urandom);
        in_valid = 1'($urandom); in_data = 16'($urandom);
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (cur_delay !== 4'd0) begin n_fail++; $display("FAIL reset_cur_delay: got %0d expected 0", cur_delay); end
        @(posedge clk);
        #1;
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got valid=%b busy=%b expected 0/0", out_valid, busy); end
        @(negedge clk);
        en = 1'b0; cfg_load = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_default_delay();
        en = 1'b1; cfg_load = 1'b0; in_valid = 1'b1; in_data = 16'hA55A;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'hA55A) begin n_fail++; $display("FAIL default_delay_out: got %b/%h expected 1/a55a", out_valid, out_data); end
        in_valid = 1'b0; in_data = 16'($urandom);
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL default_delay_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_max_delay();
        en = 1'b1; cfg_load = 1'b1; cfg_delay = 4'd15; in_valid = 1'b0;
        tick();
        cfg_load = 1'b0;
        for (int k = 0; k < 40 && busy === 1'b1; k++) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL max_delay_busy_timeout: got %b expected 0", busy); end
        for (int j = 0; j < 47; j++) begin
            in_valid = (j < 32);
            in_data  = (j < 32) ? 16'(j) : 16'($urandom);
            tick();
            n_tests++;
            if (j >= 15 && j - 15 < 32) begin
                if (out_valid !== 1'b1 || out_data !== 16'(j - 15)) begin
                    n_fail++; $display("FAIL max_delay_stream[%0d]: got %b/%h expected 1/%h", j, out_valid, out_data, 16'(j - 15));
                end
            end else if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL max_delay_gap[%0d]: got %b expected 0", j, out_valid);
            end
        end
    endtask

    task automatic test_stall();
        en = 1'b1; cfg_load = 1'b1; cfg_delay = 4'd4; in_valid = 1'b0;
        tick();
        cfg_load = 1'b0;
        for (int k = 0; k < 20 && busy === 1'b1; k++) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_timeout: got %b expected 0", busy); end
        in_valid = 1'b1; in_data = 16'h0F0F; tick();
        in_data = 16'h1234; tick();
        in_valid = 1'b0;
        for (int e = 2; e <= 3; e++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_pre[%0d]: got %b expected 0", e, out_valid); end
        end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'h0F0F) begin n_fail++; $display("FAIL stall_first: got %b/%h expected 1/0f0f", out_valid, out_data); end
        en = 1'b0;
        for (int s = 0; s < 7; s++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 16'h0F0F || cur_delay !== 4'd4 || busy !== 1'b0) begin
                n_fail++; $display("FAIL stall_frozen[%0d]: got %b/%h d=%0d busy=%b expected 1/0f0f d=4 busy=0", s, out_valid, out_data, cur_delay, busy);
            end
        end
        en = 1'b1; in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'h1234) begin n_fail++; $display("FAIL stall_emerge: got %b/%h expected 1/1234", out_valid, out_data); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_reconfig();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_reset();
        en = 1'b1; cfg_load = 1'b1; cfg_delay = 4'd8; in_valid = 1'b0;
        tick();
        cfg_load = 1'b0;
        for (int k = 0; k < 20 && busy === 1'b1; k++) tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reconfig_busy_timeout: got %b expected 0", busy); end
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reconfig_inflight[%0d]: got %b expected 0", k, out_valid); end
        end
        cfg_load = 1'b1; cfg_delay = 4'd2; in_valid = 1'b1; in_data = 16'hBEEF;
        tick();
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1 || cur_delay !== 4'd2) begin n_fail++; $display("FAIL reconfig_load: got %b busy=%b d=%0d expected 0 busy=1 d=2", out_valid, busy, cur_delay); end
`ifdef DELAY_LINE_STATS_EN
        n_tests++; if (drop_count !== 16'd8 || sample_count !== 16'd0) begin n_fail++; $display("FAIL stats_load: got drop=%0d samp=%0d expected 8/0", drop_count, sample_count); end
`endif
        cfg_load = 1'b0; in_valid = 1'b0; in_data = 16'($urandom);
        tick();
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL reconfig_l1: got %b busy=%b expected 0 busy=1", out_valid, busy); end
        tick();
        n_tests++; if (out_valid !== 1'b1 || out_data !== 16'hBEEF || busy !== 1'b1) begin n_fail++; $display("FAIL reconfig_l2: got %b/%h busy=%b expected 1/beef busy=1", out_valid, out_data, busy); end
`ifdef DELAY_LINE_STATS_EN
        n_tests++; if (sample_count !== 16'd1 || drop_count !== 16'd8) begin n_fail++; $display("FAIL stats_emerge: got samp=%0d drop=%0d expected 1/8", sample_count, drop_count); end
`endif
        tick();
        n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reconfig_l3: got %b busy=%b expected 0 busy=0", out_valid, busy); end
        for (int k = 0; k < 12; k++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reconfig_ghost[%0d]: got %b expected 0", k, out_valid); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en        = ($urandom_range(3) != 0);
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            cfg_load  = ($urandom_range(19) == 0);
            cfg_delay = 4'($urandom);
            tick();
            n_tests++; if (out_valid !== m_ov) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, out_valid, m_ov); end
            if (m_ov) begin
                n_tests++; if (out_data !== m_od) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", c, out_data, m_od); end
            end
            n_tests++; if (busy !== (m_busy_left > 0)) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy, (m_busy_left > 0)); end
            n_tests++; if (cur_delay !== 4'(m_delay)) begin n_fail++; $display("FAIL rand_delay[%0d]: got %0d expected %0d", c, cur_delay, m_delay); end
`ifdef DELAY_LINE_STATS_EN
            n_tests++; if (sample_count !== 16'(m_samples) || drop_count !== 16'(m_drops)) begin n_fail++; $display("FAIL rand_stats[%0d]: got %0d/%0d expected %0d/%0d", c, sample_count, drop_count, m_samples, m_drops); end
`endif
        end
        cfg_load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; cfg_load = 1'b0; cfg_delay = '0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_default_delay();
        test_max_delay();
        test_stall();
        test_reconfig();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
